psum_in_data_unpack: RTL and testbench
======================================

// Module: psum_in_data_unpack
// PURPOSE
//  AXI4-Stream slave. Unpacks packed 32-bit psum words into a 1-bit-per-beat stream for the PE array.
//  Reverse of the psum output packer: bit 0 of each word is emitted first (LSB first); tlast ends a layer.
//  Sits between the DMA read channel (S_AXIS) and the PE psum input port.
// PARAMETERS
//  C_S_AXIS_TDATA_WIDTH  32  word width, power of 2 (>=8)
//  PTR_W  clogb2(C_S_AXIS_TDATA_WIDTH-1)  bit-pointer width (5 for 32); derived, do not override
// PORTS
//  clk            in   1       clock, all logic rising-edge
//  rst            in   1       asynchronous reset, active-high
//  s_axis_tdata   in   32      packed psum word
//  s_axis_tvalid  in   1       word valid
//  s_axis_tlast   in   1       last word of layer
//  s_axis_tready  out  1       word accepted when tvalid&tready
//  tail_bits      in   PTR_W   valid bits in the tlast word (0 means 32); sampled with the tlast word
//  flush          in   1       sync abort: drop all buffered bits
//  out_valid      out  1       bit valid
//  out_data       out  1       psum bit
//  out_last       out  1       high with the final bit of a layer
//  out_ready      in   1       downstream accepts bit when out_valid&out_ready
//  busy           out  1       any word or bit held internally
// BEHAVIOUR
//  Reset (async, rst=1): s_axis_tready=0, out_valid=0, out_data=0, out_last=0, busy=0, bit_ptr=0, FSM=EMPTY.
//  First rising edge after rst release: tready=1. All outputs registered.
//  FSM: EMPTY -> SHIFT on word accept. SHIFT -> EMPTY on transfer of bit at end_ptr, no next word held.
//   SHIFT -> SHIFT on that transfer if a next word is held (PREFETCH_EN only).
//  end_ptr = word_tlast ? (tail_bits==0 ? 31 : tail_bits-1) : 31.
//  Latency: word accepted at cycle N -> out_valid=1, out_data=tdata[0] at N+1.
//  Bit k advances to k+1 only on out_valid&out_ready. out_data/out_last held stable while stalled.
//  out_last=1 only with the bit at end_ptr of a tlast word; otherwise 0.
//  bit_ptr resets to 0 at every word boundary. No carry between words.
//  flush: next cycle out_valid=0, out_last=0, registers emptied, FSM=EMPTY, bit_ptr=0. tready=0 during flush cycle.
//  flush and accept in the same cycle: flush wins, no word accepted (tready already 0).
//  Reset mid-word: bits discarded, no partial out_last.
//  busy = (FSM!=EMPTY) | hold_full.
// CONFIGURATION
//  PSUM_UNPACK_PREFETCH_EN defined: second holding register (word+tlast+tail_bits); tready = ~hold_full.
//   Hold loads in the shift register on the same edge the end_ptr bit transfers.
//   Zero bubbles: continuous words give 1 bit/cycle.
//  Undefined: single word register; tready = (FSM==EMPTY) registered.
//   One bubble cycle per word (33 cycles per 32-bit word at out_ready=1).
// STRUCTURE
//  Shared package psum_pkg: C_S_AXIS_TDATA_WIDTH default, PTR_W, FSM state encoding (EMPTY=1'b0, SHIFT=1'b1),
//   clogb2 function.
//  Sub-module psum_word_hold (one word+tlast+tail register with full flag); instantiated only under PREFETCH_EN.
// TESTING
//  1 word 0x0000_0005, tlast=0, out_ready=1 -> bits 1,0,1, then 29 zeros, cycles N+1..N+32; out_last=0 throughout.
//  2 word 0x0000_0006, tlast=1, tail_bits=3 -> bits 0,1,1; out_last=1 on 3rd bit only; FSM EMPTY after.
//  3 word 0xFFFF_FFFF; out_ready low cycles 3-7 -> out_data=1 and bit index held; exactly 32 bits delivered.
//  4 two back-to-back words, out_ready=1 -> 64 bits in 65 cycles without PREFETCH_EN, 64 cycles with it.
//  5 flush at bit 10 of word 0x8000_0000 -> out_valid=0 next cycle; next word 0x1 emits bit 1 first.
//  6 rst pulse at bit 20 -> all outputs 0 immediately; after release new word emits bit 0 first.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared constants, bit-pointer sizing and FSM encoding for the psum unpack path.
// No logic; imported by the unpacker and its holding register.
package psum_pkg;

    localparam int PSUM_TDATA_W = 32;

    // Number of bits needed to represent value (clogb2(31) = 5).
    function automatic int clogb2(input int value);
        int v;
        int res;
        v   = value;
        res = 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    localparam int PSUM_PTR_W = clogb2(PSUM_TDATA_W - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } psum_state_t;

endpackage

// File: rtl/psum_word_hold.sv
// One-entry holding register (word + tlast + tail_bits) with a full flag.
// Latency: loads on the accepting edge; backpressure is the caller's job (stall while full).
module psum_word_hold #(
    parameter int W     = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             unload,
    input  logic             clear,
    input  logic [W-1:0]     word_in,
    input  logic             last_in,
    input  logic [PTR_W-1:0] tail_in,
    output logic             full,
    output logic [W-1:0]     word,
    output logic             last,
    output logic [PTR_W-1:0] tail
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            word <= '0;
            last <= 1'b0;
            tail <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            word <= word_in;
            last <= last_in;
            tail <= tail_in;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/psum_in_data_unpack.sv
// AXI4-Stream slave unpacking psum words LSB-first into a 1-bit stream; PSUM_UNPACK_PREFETCH_EN adds a second word buffer.
// Latency: word accepted at N gives bit 0 at N+1; one bubble per word unless prefetch is enabled.
// Backpressure: out_ready low freezes the current bit; s_axis_tready drops while no buffer is free or during flush.
module psum_in_data_unpack
    import psum_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = PSUM_TDATA_W,
    // derived from the word width; not meant to be overridden
    parameter int PTR_W = clogb2(C_S_AXIS_TDATA_WIDTH - 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    input  logic [PTR_W-1:0]                tail_bits,
    input  logic                            flush,
    output logic                            out_valid,
    output logic                            out_data,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int W = C_S_AXIS_TDATA_WIDTH;

    psum_state_t      state_q, state_d;
    logic [W-1:0]     word_q, word_d;
    logic             word_last_q, word_last_d;
    logic [PTR_W-1:0] end_ptr_q, end_ptr_d;
    logic [PTR_W-1:0] bit_ptr_q, bit_ptr_d;
    logic [PTR_W-1:0] nxt_ptr;
    logic             out_valid_d, out_data_d, out_last_d;
    logic             tready_q, tready_d;
    logic             accept, bit_xfer, at_end;
    logic             load_shift;
    logic [W-1:0]     ld_word;
    logic             ld_last;
    logic [PTR_W-1:0] ld_tail, ld_end;
    logic             hold_full;

    // tail_bits of 0 means the whole word is valid
    function automatic logic [PTR_W-1:0] end_ptr_of(input logic last, input logic [PTR_W-1:0] tail);
        if (last && (tail != '0))
            return tail - 1'b1;
        return '1;
    endfunction

    assign s_axis_tready = tready_q & ~flush;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign bit_xfer      = out_valid & out_ready & (state_q == SHIFT);
    assign at_end        = (bit_ptr_q == end_ptr_q);
    assign nxt_ptr       = bit_ptr_q + 1'b1;
    assign ld_end        = end_ptr_of(ld_last, ld_tail);
    assign busy          = (state_q != EMPTY) | hold_full;

`ifdef PSUM_UNPACK_PREFETCH_EN
    logic             hold_load, hold_unload;
    logic             word_done;
    logic [W-1:0]     hold_word;
    logic             hold_last;
    logic [PTR_W-1:0] hold_tail;

    assign word_done = bit_xfer & at_end;

    psum_word_hold #(
        .W     (W),
        .PTR_W (PTR_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .unload  (hold_unload),
        .clear   (flush),
        .word_in (s_axis_tdata),
        .last_in (s_axis_tlast),
        .tail_in (tail_bits),
        .full    (hold_full),
        .word    (hold_word),
        .last    (hold_last),
        .tail    (hold_tail)
    );
`else
    assign hold_full = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        word_last_d = word_last_q;
        end_ptr_d   = end_ptr_q;
        bit_ptr_d   = bit_ptr_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        tready_d    = tready_q;
        load_shift  = 1'b0;
        ld_word     = s_axis_tdata;
        ld_last     = s_axis_tlast;
        ld_tail     = tail_bits;
`ifdef PSUM_UNPACK_PREFETCH_EN
        hold_load   = 1'b0;
        hold_unload = 1'b0;
`endif
        if (flush) begin
            state_d     = EMPTY;
            bit_ptr_d   = '0;
            out_valid_d = 1'b0;
            out_data_d  = 1'b0;
            out_last_d  = 1'b0;
            tready_d    = 1'b1;
        end else begin
            if (bit_xfer) begin
                if (at_end) begin
                    state_d     = EMPTY;
                    bit_ptr_d   = '0;
                    out_valid_d = 1'b0;
                    out_data_d  = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    bit_ptr_d  = nxt_ptr;
                    out_data_d = word_q[nxt_ptr];
                    out_last_d = word_last_q && (nxt_ptr == end_ptr_q);
                end
            end
`ifdef PSUM_UNPACK_PREFETCH_EN
            // the held word slides in on the same edge the final bit leaves
            if (word_done && hold_full) begin
                load_shift  = 1'b1;
                hold_unload = 1'b1;
                ld_word     = hold_word;
                ld_last     = hold_last;
                ld_tail     = hold_tail;
            end else if (accept) begin
                if ((state_q == EMPTY) || word_done)
                    load_shift = 1'b1;
                else
                    hold_load = 1'b1;
            end
`else
            if (accept)
                load_shift = 1'b1;
`endif
            if (load_shift) begin
                state_d     = SHIFT;
                word_d      = ld_word;
                word_last_d = ld_last;
                end_ptr_d   = ld_end;
                bit_ptr_d   = '0;
                out_valid_d = 1'b1;
                out_data_d  = ld_word[0];
                out_last_d  = ld_last && (ld_end == '0);
            end
`ifdef PSUM_UNPACK_PREFETCH_EN
            tready_d = ~((hold_full & ~hold_unload) | hold_load);
`else
            tready_d = (state_d == EMPTY);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            word_q      <= '0;
            word_last_q <= 1'b0;
            end_ptr_q   <= '0;
            bit_ptr_q   <= '0;
            out_valid   <= 1'b0;
            out_data    <= 1'b0;
            out_last    <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            word_last_q <= word_last_d;
            end_ptr_q   <= end_ptr_d;
            bit_ptr_q   <= bit_ptr_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            out_last    <= out_last_d;
            tready_q    <= tready_d;
        end
    end

endmodule

// File: tb/tb_psum_in_data_unpack.sv
// Directed bench for psum_in_data_unpack: expected bits queued at issue, checked by an output monitor.
module tb_psum_in_data_unpack;

    localparam int W  = 32;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [PW-1:0] tail_bits = '0;
    logic          flush = 1'b0;
    logic          out_valid, out_data, out_last;
    logic          out_ready = 1'b1;
    logic          busy;

    typedef struct packed {
        logic data;
        logic last;
    } exp_t;

    exp_t sb[$];
    int   cyc_log[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   pop_count = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psum_in_data_unpack #(.C_S_AXIS_TDATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .tail_bits     (tail_bits),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transferred bit is popped and compared
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_bit: got data=%0b last=%0b expected no output", out_data, out_last);
            end else begin
                e = sb.pop_front();
                if ({out_data, out_last} !== {e.data, e.last}) begin
                    n_fail++;
                    $display("FAIL bit_%0d: got data=%0b last=%0b expected data=%0b last=%0b",
                             pop_count, out_data, out_last, e.data, e.last);
                end
            end
            cyc_log.push_back(cyc);
            pop_count++;
        end
    end

    task automatic send_word(input logic [W-1:0] d, input logic l, input logic [PW-1:0] t, input int npush);
        int   endp;
        logic ok;
        endp = l ? ((t == 0) ? 31 : int'(t) - 1) : 31;
        for (int i = 0; i < npush && i <= endp; i++)
            sb.push_back(exp_t'({d[i], (l && i == endp)}));
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        tail_bits     = t;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        check("handshake", ok, 1);
    endtask

    task automatic wait_pops(input int target);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(posedge clk);
            if (pop_count >= target) ok = 1'b1;
        end
        check("pop_wait", ok, 1);
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(posedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        #1;
        check("drain", ok, 1);
    endtask

    initial begin
        int base;
        int span;
        int exp_span;

        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_rst", s_axis_tready, 1);

        // 1: 0x5, no tlast
        send_word(32'h0000_0005, 1'b0, '0, 32);
        check("t1_lat_valid", out_valid, 1);
        check("t1_lat_data", out_data, 1);
        check("t1_lat_last", out_last, 0);
        wait_drain();
        check("t1_busy", busy, 0);

        // 2: 0x6, tlast, 3 valid bits
        send_word(32'h0000_0006, 1'b1, 5'd3, 32);
        wait_drain();
        check("t2_busy", busy, 0);
        check("t2_valid", out_valid, 0);

        // 3: all ones with out_ready stalled for 5 cycles after 3 bits
        base = pop_count;
        send_word(32'hFFFF_FFFF, 1'b1, '0, 32);
        wait_pops(base + 3);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            check("t3_stall_valid", out_valid, 1);
            check("t3_stall_data", out_data, 1);
            check("t3_stall_pops", pop_count - base, 3);
        end
        out_ready = 1'b1;
        wait_drain();
        check("t3_bit_count", pop_count - base, 32);

        // 4: two back-to-back words
        base = pop_count;
        send_word(32'hA5A5_0F0F, 1'b0, '0, 32);
        send_word(32'h1234_5678, 1'b1, '0, 32);
        wait_drain();
`ifdef PSUM_UNPACK_PREFETCH_EN
        exp_span = 64;
`else
        exp_span = 65;
`endif
        span = (cyc_log.size() >= base + 64) ? (cyc_log[base + 63] - cyc_log[base] + 1) : -1;
        check("t4_span", span, exp_span);
        check("t4_busy", busy, 0);

        // 5: flush while bit 10 of 0x8000_0000 is presented
        base = pop_count;
        send_word(32'h8000_0000, 1'b0, '0, 10);
        wait_pops(base + 10);
        #1;
        out_ready = 1'b0;
        flush = 1'b1;
        #1;
        check("t5_flush_tready", s_axis_tready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t5_flush_valid", out_valid, 0);
        check("t5_flush_last", out_last, 0);
        check("t5_flush_busy", busy, 0);
        out_ready = 1'b1;
        send_word(32'h0000_0001, 1'b1, 5'd1, 32);
        check("t5_first_data", out_data, 1);
        check("t5_first_last", out_last, 1);
        wait_drain();

        // 6: reset pulse while bit 20 is presented
        base = pop_count;
        send_word(32'hFFFF_FFFF, 1'b0, '0, 20);
        wait_pops(base + 20);
        #1;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_last", out_last, 0);
        check("t6_rst_tready", s_axis_tready, 0);
        check("t6_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_tready_back", s_axis_tready, 1);
        out_ready = 1'b1;
        send_word(32'h0000_0002, 1'b1, 5'd2, 32);
        check("t6_first_valid", out_valid, 1);
        check("t6_first_data", out_data, 0);
        wait_drain();
        check("t6_busy", busy, 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
